// File: rtl/ainv_pkg.sv
// Shared constants for the 2x2 A-inverse multiplier: FSM encoding, accumulator
// width and element indices.
package ainv_pkg;

  // Wide enough for the sum of two 32x24 signed products.
  localparam int unsigned AccW = 57;

  localparam int unsigned NumElem = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StNorm,
    StHold
  } ainv_state_e;

  // Element indices, row-major: {row, col}.
  localparam logic [1:0] IdxA11 = 2'd0;
  localparam logic [1:0] IdxA12 = 2'd1;
  localparam logic [1:0] IdxA21 = 2'd2;
  localparam logic [1:0] IdxA22 = 2'd3;

  localparam logic [2:0] MacLast = 3'd7;

endpackage

// File: rtl/ainv_mac.sv
// Single shared signed multiplier feeding a 57-bit accumulator. The sum output is
// the value the accumulator will take on the next enabled edge.
module ainv_mac
  import ainv_pkg::*;
#(
  parameter int unsigned W_A = 32,
  parameter int unsigned W_B = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [W_A-1:0]  a,
  input  logic [W_B-1:0]  b,
  output logic [AccW-1:0] sum
);

  localparam int unsigned PW = W_A + W_B;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic [AccW-1:0]      prod_ext;
  logic [AccW-1:0]      acc_q;

  assign a_ext    = signed'({{W_B{a[W_A-1]}}, a});
  assign b_ext    = signed'({{W_A{b[W_B-1]}}, b});
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(AccW - PW){prod[PW-1]}}, prod};

  // Clear starts a new dot product with the current product instead of zero.
  assign sum = (clear ? '0 : acc_q) + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/ainv_mult.sv
// A_inv = R_inv * Q^T for 2x2 fixed-point matrices using one time-multiplexed MAC.
// Define AINV_SAT_EN to clamp out-of-range results and drive O_sat; otherwise results wrap.
module ainv_mult
  import ainv_pkg::*;
#(
  parameter int unsigned W_R    = 32,
  parameter int unsigned W_Q    = 24,
  parameter int unsigned Q_FRAC = 8
) (
  input  logic           I_sys_clk,
  input  logic           I_sys_rstn,
  input  logic           I_valid,
  output logic           O_ready,
  input  logic [W_R-1:0] I_Rinv11,
  input  logic [W_R-1:0] I_Rinv12,
  input  logic [W_R-1:0] I_Rinv21,
  input  logic [W_R-1:0] I_Rinv22,
  input  logic [W_Q-1:0] I_Q11,
  input  logic [W_Q-1:0] I_Q12,
  input  logic [W_Q-1:0] I_Q21,
  input  logic [W_Q-1:0] I_Q22,
  output logic [W_R-1:0] O_A11_inv,
  output logic [W_R-1:0] O_A12_inv,
  output logic [W_R-1:0] O_A21_inv,
  output logic [W_R-1:0] O_A22_inv,
  output logic           O_valid,
  input  logic           I_ready,
  output logic           O_sat
);

  ainv_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic        accept;

  logic [W_R-1:0]  r_q   [NumElem];
  logic [W_Q-1:0]  q_q   [NumElem];
  logic [AccW-1:0] sum_q [NumElem];
  logic [W_R-1:0]  a_q   [NumElem];

  logic [1:0]      mac_elem;
  logic            mac_k;
  logic            mac_en;
  logic [W_R-1:0]  mac_a;
  logic [W_Q-1:0]  mac_b;
  logic [AccW-1:0] mac_sum;

  logic signed [AccW-1:0] shifted  [NumElem];
  logic [W_R-1:0]         norm_val [NumElem];
  logic [NumElem-1:0]     norm_ovf;

  assign accept = I_valid && ready_q;

  // Count = {element, k}: each element gets its k=1 then k=2 product back to back.
  assign mac_elem = cnt_q[2:1];
  assign mac_k    = cnt_q[0];
  assign mac_en   = (state_q == StMac);
  assign mac_a    = r_q[{mac_elem[1], mac_k}];
  assign mac_b    = q_q[{mac_elem[0], mac_k}];

  ainv_mac #(
    .W_A (W_R),
    .W_B (W_Q)
  ) u_mac (
    .clk    (I_sys_clk),
    .rst_n  (I_sys_rstn),
    .clear  (~mac_k),
    .enable (mac_en),
    .a      (mac_a),
    .b      (mac_b),
    .sum    (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMac;
          cnt_d   = '0;
        end
      end
      StMac: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == MacLast) state_d = StNorm;
      end
      StNorm: state_d = StHold;
      StHold: begin
        if (I_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Arithmetic shift floors toward minus infinity; overflow means the bits above
  // the W_R-bit sign position are not all copies of the sign.
  always_comb begin
    for (int e = 0; e < NumElem; e++) begin
      shifted[e]  = $signed(sum_q[e]) >>> Q_FRAC;
      norm_ovf[e] = ~((&shifted[e][AccW-1:W_R-1]) | ~(|shifted[e][AccW-1:W_R-1]));
`ifdef AINV_SAT_EN
      if (norm_ovf[e]) begin
        norm_val[e] = shifted[e][AccW-1] ? {1'b1, {(W_R-1){1'b0}}} : {1'b0, {(W_R-1){1'b1}}};
      end else begin
        norm_val[e] = shifted[e][W_R-1:0];
      end
`else
      norm_val[e] = shifted[e][W_R-1:0];
`endif
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int e = 0; e < NumElem; e++) begin
        r_q[e]   <= '0;
        q_q[e]   <= '0;
        sum_q[e] <= '0;
        a_q[e]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StIdle);
      if (accept) begin
        r_q[0] <= I_Rinv11;
        r_q[1] <= I_Rinv12;
        r_q[2] <= I_Rinv21;
        r_q[3] <= I_Rinv22;
        q_q[0] <= I_Q11;
        q_q[1] <= I_Q12;
        q_q[2] <= I_Q21;
        q_q[3] <= I_Q22;
      end
      if (mac_en && mac_k) sum_q[mac_elem] <= mac_sum;
      if (state_q == StNorm) begin
        for (int e = 0; e < NumElem; e++) a_q[e] <= norm_val[e];
      end
    end
  end

`ifdef AINV_SAT_EN
  logic sat_q;

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      sat_q <= 1'b0;
    end else if (state_q == StNorm) begin
      sat_q <= |norm_ovf;
    end
  end

  assign O_sat = sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^norm_ovf;
  assign O_sat      = 1'b0;
`endif

  assign O_ready   = ready_q;
  assign O_valid   = (state_q == StHold);
  assign O_A11_inv = a_q[IdxA11];
  assign O_A12_inv = a_q[IdxA12];
  assign O_A21_inv = a_q[IdxA21];
  assign O_A22_inv = a_q[IdxA22];

endmodule

// File: tb/tb_ainv_mult.sv
// Bench for ainv_mult: vector table plus scoreboard, with backpressure, mid-job reset
// and back-to-back throughput sequences.
module tb_ainv_mult;

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [3:0][23:0] q;
    logic [3:0][31:0] a;
    logic             sat;
  } vec_t;

  localparam longint SatMax = 64'sd2147483647;
  localparam longint SatMin = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [3:0][31:0] in_r = '0;
  logic [3:0][23:0] in_q = '0;
  logic             o_ready, o_valid, o_sat;
  logic [31:0]      a11, a12, a21, a22;
  logic [3:0][31:0] dut_a;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  vec_t sb[$];
  vec_t exp_v;
  vec_t tbl[6];

  assign dut_a = {a22, a21, a12, a11};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ainv_mult dut (
    .I_sys_clk  (clk),
    .I_sys_rstn (rstn),
    .I_valid    (i_valid),
    .O_ready    (o_ready),
    .I_Rinv11   (in_r[0]),
    .I_Rinv12   (in_r[1]),
    .I_Rinv21   (in_r[2]),
    .I_Rinv22   (in_r[3]),
    .I_Q11      (in_q[0]),
    .I_Q12      (in_q[1]),
    .I_Q21      (in_q[2]),
    .I_Q22      (in_q[3]),
    .O_A11_inv  (a11),
    .O_A12_inv  (a12),
    .O_A21_inv  (a21),
    .O_A22_inv  (a22),
    .O_valid    (o_valid),
    .I_ready    (i_ready),
    .O_sat      (o_sat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] r11, r12, r21, r22,
                              input logic [23:0] q11, q12, q21, q22,
                              input logic [31:0] x11, x12, x21, x22, input logic s);
    vec_t v;
    v.r = {r22, r21, r12, r11};
    v.q = {q22, q21, q12, q11};
    v.a = {x22, x21, x12, x11};
    v.sat = s;
    return v;
  endfunction

  // Reference: A(i,j) = R(i,1)Q(j,1) + R(i,2)Q(j,2), floor-shift, then clamp or wrap.
  function automatic vec_t model(input vec_t v);
    vec_t   o;
    longint s, sh;
    logic [63:0] t;
    o = v;
    o.sat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = longint'($signed(v.r[i*2])) * longint'($signed(v.q[j*2]))
          + longint'($signed(v.r[i*2+1])) * longint'($signed(v.q[j*2+1]));
        sh = s >>> 8;
        t = sh;
`ifdef AINV_SAT_EN
        if (sh > SatMax) begin
          o.a[i*2+j] = 32'h7FFFFFFF;
          o.sat = 1'b1;
        end else if (sh < SatMin) begin
          o.a[i*2+j] = 32'h80000000;
          o.sat = 1'b1;
        end else begin
          o.a[i*2+j] = t[31:0];
        end
`else
        o.a[i*2+j] = t[31:0];
`endif
      end
    end
    return o;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      v.r[k] = $urandom();
      v.q[k] = 24'($urandom());
    end
    return model(v);
  endfunction

  // Drive one job, optionally track it, and check O_valid is seen at the 10th edge.
  task automatic run_job(input vec_t v, input bit push);
    int n;
    in_r = v.r;
    in_q = v.q;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(o_ready), 64'd1);
    if (push) sb.push_back(v);
    @(negedge clk);
    i_valid = 1'b0;
    in_r = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_q = {$urandom(), $urandom(), $urandom()};
    n = 1;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd10);
  endtask

  always @(negedge clk) begin
    #1;
    if (rstn && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: unexpected result A11=%h, expected none", a11);
      end else begin
        exp_v = sb.pop_front();
        for (int e = 0; e < 4; e++) begin
          check($sformatf("result_a%0d", e), 64'(dut_a[e]), 64'(exp_v.a[e]));
        end
        check("result_sat", 64'(o_sat), 64'(exp_v.sat));
      end
    end
  end

  initial begin
    int n, prev;
    bit phantom;
    vec_t v;

    tbl[0] = mk(32'h00010000, 32'h0, 32'h0, 32'h00010000, 24'h100, 24'h0, 24'h0, 24'h100,
                32'h00010000, 32'h0, 32'h0, 32'h00010000, 1'b0);
    tbl[1] = mk(32'h00020000, 32'hFFFF8000, 32'h0, 32'h00010000,
                24'h0, 24'h100, 24'h100, 24'h0,
                32'hFFFF8000, 32'h00020000, 32'h00010000, 32'h0, 1'b0);
`ifdef AINV_SAT_EN
    tbl[2] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0,
                32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 1'b1);
    tbl[3] = mk(32'h80000000, 32'h80000000, 32'h0, 32'h0, 24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0,
                32'h80000000, 32'h0, 32'h0, 32'h0, 1'b1);
`else
    tbl[2] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0,
                32'hFEFF0000, 32'h0, 32'h0, 32'h0, 1'b0);
    tbl[3] = mk(32'h80000000, 32'h80000000, 32'h0, 32'h0, 24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0,
                32'h01000000, 32'h0, 32'h0, 32'h0, 1'b0);
`endif
    // Largest in-range value and floor of small negatives (-1 >>> 8 stays -1).
    tbl[4] = mk(32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 24'h100, 24'h0, 24'h1, 24'h0,
                32'h7FFFFFFF, 32'h007FFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    tbl[5] = rand_vec();

    // Reset state
    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_sat", 64'(o_sat), 64'd0);
    check("rst_a", 64'(dut_a), 64'd0);
    #10 rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);

    // Table vectors with I_ready held high
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i], 1'b1);
      @(negedge clk);
      check("valid_drop", 64'(o_valid), 64'd0);
      check("ready_rise", 64'(o_ready), 64'd1);
    end

    // Backpressure: hold 20 cycles while offering a competing job
    i_ready = 1'b0;
    run_job(tbl[1], 1'b1);
    for (int k = 0; k < 20; k++) begin
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_ready", 64'(o_ready), 64'd0);
      check("bp_a", 64'(dut_a), 64'(tbl[1].a));
      i_valid = 1'b1;
      in_r = tbl[0].r;
      in_q = tbl[0].q;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 64'(o_valid), 64'd0);
    check("bp_ready_rise", 64'(o_ready), 64'd1);
    phantom = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) phantom = 1'b1;
    end
    check("bp_no_phantom", 64'(phantom), 64'd0);

    // Reset during MAC at count 4
    in_r = tbl[0].r;
    in_q = tbl[0].q;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd0);
    check("midrst_sat", 64'(o_sat), 64'd0);
    check("midrst_a", 64'(dut_a), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    phantom = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) phantom = 1'b1;
    end
    check("midrst_no_partial", 64'(phantom), 64'd0);
    run_job(tbl[0], 1'b1);
    @(negedge clk);

    // Back-to-back with I_valid and I_ready held high
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      v = rand_vec();
      in_r = v.r;
      in_q = v.q;
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", 64'(o_ready), 64'd1);
      if (j > 0) check("b2b_period", 64'(cyc - prev), 64'd11);
      prev = cyc;
      sb.push_back(v);
      @(negedge clk);
    end
    i_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
